// File: rtl/led_scan_pkg.sv
// rtl/led_scan_pkg.sv - shared types and constants for the LED matrix scanner
//
// Contents:
//   NUM_ROWS, NUM_COLS, BITS_PER_ROW  matrix geometry (16 rows, 16 bi-colour columns)
//   scan_state_t                      row scan phases: blank, shift, latch, display
//   pixel_frame_t                     one colour plane, indexed [row][col]
//   row_select_n()                    active-low one-hot row enable for a row index

package led_scan_pkg;

    localparam int NUM_ROWS     = 16;
    localparam int NUM_COLS     = 16;
    localparam int BITS_PER_ROW = 2 * NUM_COLS;
    localparam int ROW_W        = $clog2(NUM_ROWS);

    typedef enum logic [1:0] {
        ST_BLANK,
        ST_SHIFT,
        ST_LATCH,
        ST_DISPLAY
    } scan_state_t;

    typedef logic [NUM_ROWS-1:0][NUM_COLS-1:0] pixel_frame_t;

    function automatic logic [NUM_ROWS-1:0] row_select_n(input logic [ROW_W-1:0] row);
        return ~(NUM_ROWS'(1) << row);
    endfunction

endpackage

// File: rtl/led_shift_serializer.sv
// rtl/led_shift_serializer.sv - 32-bit parallel-in serial-out column loader with SRCLK generation
//
// Ports:
//   CLK    in   system clock
//   RST    in   synchronous active-high reset
//   start  in   one-cycle pulse; loads data and begins shifting on the next cycle
//   data   in   [31:0] word to shift, bit 31 first
//   SER    out  serial data, changes only at the start of each SRCLK low phase
//   SRCLK  out  shift clock: SHIFT_DIV cycles low, then SHIFT_DIV cycles high, per bit
//   done   out  high during the final cycle of the last bit's high phase
//
// After start, the word occupies exactly 2*SHIFT_DIV*32 cycles and SRCLK is low
// again on the cycle after done.

module led_shift_serializer
    import led_scan_pkg::*;
#(
    parameter int SHIFT_DIV = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    start,
    input  logic [BITS_PER_ROW-1:0] data,
    output logic                    SER,
    output logic                    SRCLK,
    output logic                    done
);

    localparam int PH_W  = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
    localparam int BIT_W = $clog2(BITS_PER_ROW);

    logic [BITS_PER_ROW-1:0] shreg;
    logic [PH_W-1:0]         phase;
    logic [BIT_W-1:0]        bit_idx;
    logic                    busy;
    logic                    srclk_q;
    logic                    phase_end;
    logic                    last_bit;

    assign phase_end = (phase == PH_W'(SHIFT_DIV - 1));
    assign last_bit  = (bit_idx == BIT_W'(BITS_PER_ROW - 1));
    assign done      = busy && srclk_q && phase_end && last_bit;

    // SER is the MSB of the shift register, so it only moves when the
    // register shifts, which happens as the high phase ends.
    assign SER   = shreg[BITS_PER_ROW-1];
    assign SRCLK = srclk_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            shreg   <= '0;
            phase   <= '0;
            bit_idx <= '0;
            busy    <= 1'b0;
            srclk_q <= 1'b0;
        end else if (start) begin
            shreg   <= data;
            phase   <= '0;
            bit_idx <= '0;
            busy    <= 1'b1;
            srclk_q <= 1'b0;
        end else if (busy) begin
            if (phase_end) begin
                phase <= '0;
                if (!srclk_q) begin
                    srclk_q <= 1'b1;
                end else begin
                    srclk_q <= 1'b0;
                    // Shift on the final bit too so SER idles at 0 once the
                    // whole word has gone out.
                    shreg   <= {shreg[BITS_PER_ROW-2:0], 1'b0};
                    if (last_bit) begin
                        busy <= 1'b0;
                    end else begin
                        bit_idx <= bit_idx + BIT_W'(1);
                    end
                end
            end else begin
                phase <= phase + PH_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// rtl/led_matrix_scanner.sv - scans a 16x16 bi-colour frame onto an LED matrix, one row at a time
//
// Optional feature macro: LED_SCAN_DIMMING_EN (adds BRIGHT[3:0] and dwell-based dimming)
//
// Ports:
//   CLK          in   system clock
//   RST          in   synchronous active-high reset
//   RedPixels    in   [15:0][15:0] red frame, [row][col]
//   GrnPixels    in   [15:0][15:0] green frame, [row][col]
//   BRIGHT       in   [3:0] brightness, only with LED_SCAN_DIMMING_EN
//   SER          out  serial column data
//   SRCLK        out  shift clock to column registers
//   LATCH        out  one-cycle storage-register latch pulse
//   ROW_N        out  [15:0] active-low one-hot row enable
//   OE_N         out  active-low column output enable
//   FRAME_START  out  one-cycle pulse in the cycle the frame snapshot is taken
//
// Row period = BLANK_CYCLES + 64*SHIFT_DIV + 1 + DWELL_CYCLES; frame = 16 rows.

module led_matrix_scanner
    import led_scan_pkg::*;
#(
    parameter int SHIFT_DIV    = 2,
    parameter int DWELL_CYCLES = 2048,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [15:0][15:0]   RedPixels,
    input  logic [15:0][15:0]   GrnPixels,
`ifdef LED_SCAN_DIMMING_EN
    input  logic [3:0]          BRIGHT,
`endif
    output logic                SER,
    output logic                SRCLK,
    output logic                LATCH,
    output logic [15:0]         ROW_N,
    output logic                OE_N,
    output logic                FRAME_START
);

    localparam int MAX_CNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT);

    scan_state_t              state;
    scan_state_t              state_d;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_d;
    logic [ROW_W-1:0]         row;
    logic [ROW_W-1:0]         row_d;
    // High for the one cycle following reset so the first post-reset edge
    // behaves like a normal entry into BLANK for row 0 (snapshot + pulse).
    logic                     rst_q;
    logic                     capture;
    logic                     ser_start;
    logic                     ser_done;
    logic                     oe_active;
    pixel_frame_t             snap_red;
    pixel_frame_t             snap_grn;
    logic [BITS_PER_ROW-1:0]  row_bits;

    // Red MSB first, then green MSB first.
    assign row_bits = {snap_red[row], snap_grn[row]};

`ifdef LED_SCAN_DIMMING_EN
    logic [3:0]   bright_q;
    logic [CNT_W:0] on_cycles;

    // Output enable is held for the first (BRIGHT+1)/16 of the dwell.
    assign on_cycles = (CNT_W + 1)'((int'(bright_q) + 1) * (DWELL_CYCLES / 16));
    assign oe_active = ({1'b0, cnt} < on_cycles);
`else
    assign oe_active = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_BLANK;
            cnt      <= '0;
            row      <= '0;
            rst_q    <= 1'b1;
            snap_red <= '0;
            snap_grn <= '0;
`ifdef LED_SCAN_DIMMING_EN
            bright_q <= '0;
`endif
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            row   <= row_d;
            rst_q <= 1'b0;
            if (capture) begin
                snap_red <= RedPixels;
                snap_grn <= GrnPixels;
`ifdef LED_SCAN_DIMMING_EN
                bright_q <= BRIGHT;
`endif
            end
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt + CNT_W'(1);
        row_d     = row;
        capture   = 1'b0;
        ser_start = 1'b0;
        if (rst_q) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            row_d   = '0;
            capture = 1'b1;
        end else begin
            unique case (state)
                ST_BLANK: begin
                    if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                        // Load the serializer now so the first bit is on SER
                        // in the very first SHIFT cycle.
                        state_d   = ST_SHIFT;
                        cnt_d     = '0;
                        ser_start = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    cnt_d = '0;
                    if (ser_done) begin
                        state_d = ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    state_d = ST_DISPLAY;
                    cnt_d   = '0;
                end
                ST_DISPLAY: begin
                    if (cnt == CNT_W'(DWELL_CYCLES - 1)) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        row_d   = row + ROW_W'(1);
                        // Wrapping back to row 0 starts a new frame.
                        capture = (row == ROW_W'(NUM_ROWS - 1));
                    end
                end
                default: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        ROW_N       = '1;
        OE_N        = 1'b1;
        LATCH       = 1'b0;
        FRAME_START = 1'b0;
        unique case (state)
            ST_BLANK: begin
                FRAME_START = !rst_q && (row == '0) && (cnt == '0);
            end
            ST_SHIFT: begin
            end
            ST_LATCH: begin
                LATCH = 1'b1;
            end
            ST_DISPLAY: begin
                ROW_N = row_select_n(row);
                OE_N  = !oe_active;
            end
            default: begin
            end
        endcase
    end

    led_shift_serializer #(
        .SHIFT_DIV (SHIFT_DIV)
    ) u_serializer (
        .CLK   (CLK),
        .RST   (RST),
        .start (ser_start),
        .data  (row_bits),
        .SER   (SER),
        .SRCLK (SRCLK),
        .done  (ser_done)
    );

endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb/tb_led_matrix_scanner.sv - self-checking bench for led_matrix_scanner against a timeline model

module tb_led_matrix_scanner;

    localparam int SD    = 1;
    localparam int DW    = 16;
    localparam int BL    = 2;
    localparam int SHEND = BL + 64 * SD;
    localparam int ROWP  = BL + 64 * SD + 1 + DW;
    localparam int FRAME = 16 * ROWP;

    logic              CLK = 1'b0;
    logic              RST;
    logic [15:0][15:0] red;
    logic [15:0][15:0] grn;
    logic              SER;
    logic              SRCLK;
    logic              LATCH;
    logic [15:0]       ROW_N;
    logic              OE_N;
    logic              FRAME_START;
`ifdef LED_SCAN_DIMMING_EN
    logic [3:0]        bright;
`endif

    logic [15:0][15:0] m_red;
    logic [15:0][15:0] m_grn;
    logic [3:0]        m_bright;
    int                t;
    int                tests;
    int                fails;
    int                oe_low_cnt;
    logic [31:0]       col_bits;
    logic [31:0]       row_stream [16];

    led_matrix_scanner #(
        .SHIFT_DIV    (SD),
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BL)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RedPixels   (red),
        .GrnPixels   (grn),
`ifdef LED_SCAN_DIMMING_EN
        .BRIGHT      (bright),
`endif
        .SER         (SER),
        .SRCLK       (SRCLK),
        .LATCH       (LATCH),
        .ROW_N       (ROW_N),
        .OE_N        (OE_N),
        .FRAME_START (FRAME_START)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    // Expected pins for cycle tt of the current frame, from the row-period
    // timeline: blank, 32 two-phase bits, one latch cycle, then the dwell.
    task automatic model(input int tt, output logic [19:0] v, output logic sv, output logic se);
        int          ft, r, o, k, on;
        logic        fs, sr, la, oe;
        logic [15:0] rn;
        logic [31:0] stream;
        ft = tt % FRAME;
        r  = ft / ROWP;
        o  = ft % ROWP;
        fs = (ft == 0);
        sr = 1'b0;
        la = 1'b0;
        oe = 1'b1;
        rn = 16'hFFFF;
        sv = 1'b0;
        se = 1'b0;
        stream = {m_red[r], m_grn[r]};
        if (o >= BL && o < SHEND) begin
            k  = o - BL;
            sr = ((k / SD) % 2) == 1;
            sv = 1'b1;
            se = stream[31 - k / (2 * SD)];
        end else if (o == SHEND) begin
            la = 1'b1;
        end else if (o > SHEND) begin
            rn = ~(16'h0001 << r);
            on = DW;
`ifdef LED_SCAN_DIMMING_EN
            on = (int'(m_bright) + 1) * DW / 16;
`endif
            oe = !((o - (SHEND + 1)) < on);
        end
        v = {fs, sr, la, oe, rn};
    endtask

    task automatic step();
        logic [19:0] ev;
        logic        sv, se;
        int          ft, r, o, pr;
        @(negedge CLK);
        model(t, ev, sv, se);
        check("pins", {12'h0, FRAME_START, SRCLK, LATCH, OE_N, ROW_N}, {12'h0, ev});
        if (sv) check("ser", {31'h0, SER}, {31'h0, se});
        ft = t % FRAME;
        r  = ft / ROWP;
        o  = ft % ROWP;
        if (o == 0) col_bits = '0;
        if (o >= BL && o < SHEND && SRCLK === 1'b1) col_bits = {col_bits[30:0], SER};
        if (o == SHEND) row_stream[r] = col_bits;
        if (ft == 0) oe_low_cnt = 0;
        if (r == 0 && o > SHEND && OE_N === 1'b0) oe_low_cnt++;
        // Inputs wander mid-frame; only the snapshot taken at frame start may show.
        if ($urandom_range(0, 3) == 0) begin
            pr = $urandom_range(0, 15);
            if (pr != 9) begin
                red[pr] = 16'($urandom);
                grn[pr] = 16'($urandom);
            end
`ifdef LED_SCAN_DIMMING_EN
            bright = 4'($urandom_range(0, 15));
`endif
        end
        t++;
        if (t % FRAME == 0) begin
            m_red = red;
            m_grn = grn;
`ifdef LED_SCAN_DIMMING_EN
            m_bright = bright;
`endif
        end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        t          = 0;
        oe_low_cnt = 0;
        col_bits   = '0;
        m_bright   = 4'd15;
        for (int i = 0; i < 16; i++) row_stream[i] = '0;
        RST = 1'b1;
        for (int i = 0; i < 16; i++) begin
            red[i] = 16'($urandom);
            grn[i] = 16'($urandom);
        end
        red[0] = 16'h8001;
        grn[0] = 16'h00F0;
        red[9] = 16'h0000;
`ifdef LED_SCAN_DIMMING_EN
        bright = 4'd7;
`endif

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_pins", {12'h0, FRAME_START, SRCLK, LATCH, OE_N, ROW_N}, 32'h0001FFFF);
        check("reset_ser", {31'h0, SER}, 32'h0);

        m_red = red;
        m_grn = grn;
`ifdef LED_SCAN_DIMMING_EN
        m_bright = bright;
`endif
        t   = 0;
        RST = 1'b0;

        // Frame 0: red[9] flips while row 5 is on, after the snapshot.
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (t == 5 * ROWP + SHEND + 4) red[9] = 16'hFFFF;
        end
        check("row0_bit_order", row_stream[0], 32'h800100F0);
        check("row9_frame0_red", {16'h0, row_stream[9][31:16]}, 32'h0000);
`ifdef LED_SCAN_DIMMING_EN
        check("dim_bright7", oe_low_cnt, 8);
`endif

        // Frame 1: the change is now visible.
        for (int i = 0; i < FRAME; i++) step();
        check("row9_frame1_red", {16'h0, row_stream[9][31:16]}, 32'hFFFF);

        // Frame 2: reset during bit 10 of row 3's shift.
        while (t <= 2 * FRAME + 3 * ROWP + BL + 2 * SD * 10) step();
        RST = 1'b1;
        @(negedge CLK);
        check("midreset_pins", {12'h0, FRAME_START, SRCLK, LATCH, OE_N, ROW_N}, 32'h0001FFFF);
        check("midreset_ser", {31'h0, SER}, 32'h0);
        for (int i = 0; i < 16; i++) begin
            if (i != 9) begin
                red[i] = 16'($urandom);
                grn[i] = 16'($urandom);
            end
        end
`ifdef LED_SCAN_DIMMING_EN
        bright = 4'd15;
        m_bright = bright;
`endif
        m_red = red;
        m_grn = grn;
        t   = 0;
        RST = 1'b0;
        for (int i = 0; i < 2 * ROWP; i++) step();
        check("restart_row0", row_stream[0], {m_red[0], m_grn[0]});
`ifdef LED_SCAN_DIMMING_EN
        check("dim_bright15", oe_low_cnt, 16);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
